// File: rtl/dcache_sa.sv
// dcache_sa: set-associative (1/2-way) write-back, write-allocate data cache with per-set LRU and hit/miss counters
//   clk_i/rst_i (async, active-low); p1_* CPU load/store port with p1_stall_o freeze;
//   mem_* 256-bit line port (enable/write/addr/data out, data/ack in); hit_cnt_o/miss_cnt_o statistics.
module dcache_sa #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      p1_addr_i,
  input  logic [31:0]      p1_data_i,
  input  logic             p1_MemRead_i,
  input  logic             p1_MemWrite_i,
  output logic [31:0]      p1_data_o,
  output logic             p1_stall_o,
  input  logic [255:0]     mem_data_i,
  input  logic             mem_ack_i,
  output logic [255:0]     mem_data_o,
  output logic [31:0]      mem_addr_o,
  output logic             mem_enable_o,
  output logic             mem_write_o,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);
  localparam int IB = $clog2(SETS);
  localparam int TW = 27 - IB;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL} state_t;
  state_t state, state_nx;
  logic [1:0] vld [SETS];
  logic [1:0] drt [SETS];
  logic [SETS-1:0] lru;
  logic [TW-1:0] tags [2][SETS];
  logic [255:0] lines [2][SETS];
  logic [255:0] fill_line;
  logic [26:0] req_line;
  logic [IB-1:0] idx, li;
  logic [TW-1:0] tag, lt;
  logic vic, retry, req, hit0, hit1, hit, hw, victim, miss, acc, unused_ok;
  assign idx = p1_addr_i[4+IB:5];
  assign tag = p1_addr_i[31:5+IB];
  // li/lt: index and tag of the missing request, held for the whole miss
  assign li = req_line[IB-1:0];
  assign lt = req_line[26:IB];
  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit0 = vld[idx][0] && tags[0][idx] == tag;
  assign hit1 = WAYS == 2 && vld[idx][1] && tags[1][idx] == tag;
  assign hit = hit0 | hit1;
  assign hw = ~hit0;
  // lowest invalid way first, otherwise the LRU way; way 0 only when direct-mapped
  assign victim = vld[idx][0] && WAYS == 2 && (!vld[idx][1] || lru[idx]);
  assign acc = state == IDLE && req && hit;
  assign miss = state == IDLE && req && !hit;
  assign p1_stall_o = state != IDLE || miss;
  assign p1_data_o = lines[hw][idx][{p1_addr_i[4:2], 5'b0} +: 32];
  assign unused_ok = ^p1_addr_i[1:0];
  always_comb begin
    state_nx = state;
    mem_enable_o = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    case (state)
      IDLE: if (miss) state_nx = vld[idx][victim] && drt[idx][victim] ? WRITEBACK : ALLOCATE;
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o = 1'b1;
        mem_addr_o = {tags[vic][li], li, 5'b0};
        mem_data_o = lines[vic][li];
        if (mem_ack_i) state_nx = ALLOCATE;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o = {req_line, 5'b0};
        if (mem_ack_i) state_nx = FILL;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      lru <= '0;
      vic <= 1'b0;
      retry <= 1'b0;
      req_line <= '0;
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
      for (int s = 0; s < SETS; s++) begin
        vld[s] <= '0;
        drt[s] <= '0;
      end
    end else begin
      state <= state_nx;
      // the access replayed right after FILL was already counted as a miss
      retry <= state == FILL;
      if (acc && !retry) hit_cnt_o <= hit_cnt_o + 1'b1;
      if (acc) lru[idx] <= ~hw;
      if (acc && p1_MemWrite_i) drt[idx][hw] <= 1'b1;
      if (miss) begin
        miss_cnt_o <= miss_cnt_o + 1'b1;
        vic <= victim;
        req_line <= p1_addr_i[31:5];
      end
      if (state == FILL) begin
        vld[li][vic] <= 1'b1;
        drt[li][vic] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (state == ALLOCATE && mem_ack_i) fill_line <= mem_data_i;
    if (state == FILL) begin
      lines[vic][li] <= fill_line;
      tags[vic][li] <= lt;
    end
    if (acc && p1_MemWrite_i) lines[hw][idx][{p1_addr_i[4:2], 5'b0} +: 32] <= p1_data_i;
  end
endmodule

// File: tb/tb_dcache_sa.sv
// tb_dcache_sa: directed table, corner sequences and randomized model check of dcache_sa
module tb_dcache_sa;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] p1_addr_i, p1_data_i, p1_data_o, mem_addr_o;
  logic p1_MemRead_i, p1_MemWrite_i, p1_stall_o, mem_ack_i, mem_enable_o, mem_write_o;
  logic [255:0] mem_data_i, mem_data_o;
  logic [31:0] hit_cnt_o, miss_cnt_o;
  logic [31:0] b_addr, b_rdata, b_maddr;
  logic b_rd, b_wr, b_stall, b_ack, b_en, b_we;
  logic [255:0] b_mdata_i, b_mdata_o;
  logic [3:0] b_hit, b_miss;
  dcache_sa #(.SETS(16), .WAYS(2), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i), .p1_data_o(p1_data_o),
    .p1_stall_o(p1_stall_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o));
  dcache_sa #(.SETS(4), .WAYS(1), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .p1_addr_i(b_addr), .p1_data_i(32'h0),
    .p1_MemRead_i(b_rd), .p1_MemWrite_i(b_wr), .p1_data_o(b_rdata),
    .p1_stall_o(b_stall), .mem_data_i(b_mdata_i), .mem_ack_i(b_ack),
    .mem_data_o(b_mdata_o), .mem_addr_o(b_maddr), .mem_enable_o(b_en),
    .mem_write_o(b_we), .hit_cnt_o(b_hit), .miss_cnt_o(b_miss));
  int n_chk = 0, n_fail = 0;
  logic [255:0] mem [logic [31:0]];
  logic [255:0] ref_mem [logic [31:0]];
  bit m_v [16][2];
  bit m_d [16][2];
  logic [31:0] m_tag [16][2];
  logic [255:0] m_line [16][2];
  int m_t [16][2];
  int tick, mh, mm;
  typedef struct {
    bit wr; logic [31:0] a, d; int kw, ka, st; logic [31:0] rd;
    bit wb; logic [31:0] wb_a, wb_w0; int h, m;
  } vec_t;
  vec_t tv [12];
  function automatic logic [255:0] line_init(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la | 32'(w << 2)) ^ 32'hA5A5_0000;
    return l;
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input int kw, input int ka,
                        output int st, output logic [31:0] rd, output int n_wb, output logic [31:0] wb_a,
                        output logic [255:0] wb_l, output int n_al, output logic [31:0] al_a);
    int cnt;
    bit done;
    logic [31:0] la;
    p1_addr_i = a; p1_data_i = d; p1_MemWrite_i = wr; p1_MemRead_i = !wr;
    st = 0; rd = 0; n_wb = 0; wb_a = 0; wb_l = 0; n_al = 0; al_a = 0; cnt = 0; done = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!p1_stall_o) begin
        rd = p1_data_o;
        done = 1;
        break;
      end
      st++;
      if (mem_enable_o) begin
        cnt++;
        if (cnt == (mem_write_o ? kw : ka)) begin
          cnt = 0;
          mem_ack_i = 1'b1;
          la = mem_addr_o;
          if (mem_write_o) begin
            n_wb++; wb_a = la; wb_l = mem_data_o; mem[la] = mem_data_o;
          end else begin
            n_al++; al_a = la; mem_data_i = mem.exists(la) ? mem[la] : line_init(la);
          end
        end
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
    end
    if (!done) chk($sformatf("timeout %0h", a), 0, 1);
    @(negedge clk);
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask
  task automatic b_access(input logic [31:0] a, output int st, output logic [31:0] rd);
    bit done;
    b_addr = a; b_rd = 1'b1; st = 0; rd = 0; done = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!b_stall) begin
        rd = b_rdata;
        done = 1;
        break;
      end
      st++;
      b_ack = b_en;
      b_mdata_i = line_init({b_addr[31:5], 5'b0});
      @(negedge clk);
      b_ack = 1'b0;
    end
    if (!done) chk($sformatf("b timeout %0h", a), 0, 1);
    @(negedge clk);
    b_rd = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int st, nwb, nal, e_st;
    logic [31:0] rd, wba, ala, e_rd, e_wba, la, a, d;
    logic [255:0] wbl, e_wbl, l;
    bit wr, e_wb, got;
    int s, w, kw, ka, st_sum;
    tv[0]  = '{0, 32'h40,  32'h0,        1, 1, 5, 32'hA5A50040, 0, 32'h0, 32'h0,        0, 1};
    tv[0].ka = 3;
    tv[1]  = '{1, 32'h44,  32'hDEADBEEF, 1, 1, 0, 32'h0,        0, 32'h0, 32'h0,        1, 1};
    tv[2]  = '{0, 32'h44,  32'h0,        1, 1, 0, 32'hDEADBEEF, 0, 32'h0, 32'h0,        2, 1};
    tv[3]  = '{0, 32'h000, 32'h0,        1, 2, 4, 32'hA5A50000, 0, 32'h0, 32'h0,        2, 2};
    tv[4]  = '{0, 32'h200, 32'h0,        1, 1, 3, 32'hA5A50200, 0, 32'h0, 32'h0,        2, 3};
    tv[5]  = '{0, 32'h000, 32'h0,        1, 1, 0, 32'hA5A50000, 0, 32'h0, 32'h0,        3, 3};
    tv[6]  = '{0, 32'h400, 32'h0,        1, 1, 3, 32'hA5A50400, 0, 32'h0, 32'h0,        3, 4};
    tv[7]  = '{0, 32'h000, 32'h0,        1, 1, 0, 32'hA5A50000, 0, 32'h0, 32'h0,        4, 4};
    tv[8]  = '{0, 32'h200, 32'h0,        1, 1, 3, 32'hA5A50200, 0, 32'h0, 32'h0,        4, 5};
    tv[9]  = '{1, 32'h000, 32'h12345678, 1, 1, 0, 32'h0,        0, 32'h0, 32'h0,        5, 5};
    tv[10] = '{0, 32'h200, 32'h0,        1, 1, 0, 32'hA5A50200, 0, 32'h0, 32'h0,        6, 5};
    tv[11] = '{0, 32'h400, 32'h0,        2, 3, 7, 32'hA5A50400, 1, 32'h0, 32'h12345678, 6, 6};
    p1_addr_i = 0; p1_data_i = 0; p1_MemRead_i = 0; p1_MemWrite_i = 0; mem_ack_i = 0; mem_data_i = 0;
    b_addr = 0; b_rd = 0; b_wr = 0; b_ack = 0; b_mdata_i = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset mem_enable", mem_enable_o, 0);
    chk("reset mem_write", mem_write_o, 0);
    chk("reset mem_addr", mem_addr_o, 0);
    chk("reset stall", p1_stall_o, 0);
    chk("reset hit_cnt", hit_cnt_o, 0);
    chk("reset miss_cnt", miss_cnt_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    b_access(32'h0, st, rd);
    chk("b first miss stall", st, 3);
    st_sum = 0;
    for (int i = 0; i < 17; i++) begin
      b_access(32'h0, st, rd);
      st_sum += st;
    end
    chk("b hit stalls", st_sum, 0);
    chk("b hit_cnt wrap", b_hit, 1);
    chk("b miss_cnt", b_miss, 1);
    b_access(32'h80, st, rd);
    chk("b conflict stall", st, 3);
    chk("b conflict data", rd, 32'hA5A50080);
    b_access(32'h0, st, rd);
    chk("b evicted reload stall", st, 3);
    chk("b miss_cnt after evict", b_miss, 3);
    for (int i = 0; i < 12; i++) begin
      access(tv[i].wr, tv[i].a, tv[i].d, tv[i].kw, tv[i].ka, st, rd, nwb, wba, wbl, nal, ala);
      chk($sformatf("v%0d stall", i), st, tv[i].st);
      if (!tv[i].wr) chk($sformatf("v%0d rdata", i), rd, tv[i].rd);
      chk($sformatf("v%0d writebacks", i), nwb, tv[i].wb);
      if (tv[i].wb) begin
        chk($sformatf("v%0d wb addr", i), wba, tv[i].wb_a);
        chk($sformatf("v%0d wb word0", i), wbl[31:0], tv[i].wb_w0);
      end
      chk($sformatf("v%0d allocates", i), nal, tv[i].st != 0);
      chk($sformatf("v%0d alloc addr", i), ala, tv[i].st != 0 ? {tv[i].a[31:5], 5'b0} : 32'h0);
      chk($sformatf("v%0d hit_cnt", i), hit_cnt_o, tv[i].h);
      chk($sformatf("v%0d miss_cnt", i), miss_cnt_o, tv[i].m);
    end
    p1_addr_i = 32'h600; p1_MemRead_i = 1'b1; got = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mem_enable_o && !mem_write_o) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst reach allocate", got, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst mem_enable", mem_enable_o, 0);
    chk("rst mem_write", mem_write_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst hit_cnt", hit_cnt_o, 0);
    chk("rst miss_cnt", miss_cnt_o, 0);
    chk("rst stall on pending miss", p1_stall_o, 1);
    p1_MemRead_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 32'h600, 0, 1, 2, st, rd, nwb, wba, wbl, nal, ala);
    l = line_init(32'h600);
    chk("reload stall", st, 4);
    chk("reload data", rd, l[31:0]);
    chk("reload alloc addr", ala, 32'h600);
    chk("reload miss_cnt", miss_cnt_o, 1);
    chk("reload hit_cnt", hit_cnt_o, 0);
    do_reset();
    ref_mem = mem;
    tick = 0; mh = 0; mm = 0;
    for (int i = 0; i < 16; i++) for (int j = 0; j < 2; j++) begin
      m_v[i][j] = 0; m_d[i][j] = 0; m_t[i][j] = 0;
    end
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      d = $urandom;
      kw = $urandom_range(1, 3);
      ka = $urandom_range(1, 3);
      s = int'(a[8:5]);
      la = {a[31:5], 5'b0};
      w = -1;
      for (int j = 0; j < 2; j++) if (m_v[s][j] && m_tag[s][j] == la) w = j;
      e_st = 0; e_wb = 0; e_wba = 0; e_wbl = 0; e_rd = 0;
      if (w < 0) begin
        mm++;
        w = !m_v[s][0] ? 0 : !m_v[s][1] ? 1 : (m_t[s][0] < m_t[s][1] ? 0 : 1);
        if (m_v[s][w] && m_d[s][w]) begin
          e_wb = 1; e_wba = m_tag[s][w]; e_wbl = m_line[s][w];
          ref_mem[e_wba] = e_wbl;
          e_st = kw;
        end
        e_st += 2 + ka;
        m_line[s][w] = ref_mem.exists(la) ? ref_mem[la] : line_init(la);
        m_v[s][w] = 1; m_d[s][w] = 0; m_tag[s][w] = la;
      end else mh++;
      tick++;
      m_t[s][w] = tick;
      if (wr) begin
        m_line[s][w][int'(a[4:2])*32 +: 32] = d;
        m_d[s][w] = 1;
      end else e_rd = m_line[s][w][int'(a[4:2])*32 +: 32];
      access(wr, a, d, kw, ka, st, rd, nwb, wba, wbl, nal, ala);
      chk($sformatf("r%0d stall", i), st, e_st);
      if (!wr) chk($sformatf("r%0d rdata", i), rd, e_rd);
      chk($sformatf("r%0d writebacks", i), nwb, e_wb);
      if (e_wb) begin
        chk($sformatf("r%0d wb addr", i), wba, e_wba);
        chk($sformatf("r%0d wb line", i), wbl, e_wbl);
      end
      chk($sformatf("r%0d allocates", i), nal, e_st != 0);
      if (e_st != 0) chk($sformatf("r%0d alloc addr", i), ala, la);
    end
    chk("random hit_cnt", hit_cnt_o, mh);
    chk("random miss_cnt", miss_cnt_o, mm);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_sa.md
# dcache_sa

Parametrised set-associative, write-back, write-allocate data cache for the MEM stage of the pipelined CPU. It generalises the existing direct-mapped `dcache_top` in three ways: configurable set count, 1- or 2-way associativity with per-set LRU, and hit/miss statistics counters. It presents the same CPU-side load/store and stall interface and the same 256-bit line memory interface, so it is a drop-in replacement between EX_MEM and MEM_WB.

## Interface
- SETS, 16, number of sets; power of 2, 2..256
- WAYS, 2, associativity; 1 or 2 only
- CNT_W, 32, width of the statistics counters
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- p1_addr_i  in  32  byte address; word-aligned
- p1_data_i  in  32  store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request; wins if both requests are high
- p1_data_o  out  32  load data; valid in the cycle p1_stall_o is low
- p1_stall_o  out  1  freezes the pipeline while high
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  one-cycle completion pulse from memory
- mem_data_o  out  256  write-back line
- mem_addr_o  out  32  line address; bits [4:0] are 0
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = write-back, 0 = refill
- hit_cnt_o  out  CNT_W  completed hits
- miss_cnt_o  out  CNT_W  misses

## Operation
- Address split: offset [4:0], word select [4:2], index [4+IB:5] with IB = log2(SETS), tag [31:5+IB].
- Per way and set: a valid bit, a dirty bit, the tag and a 256-bit line. Per set: one LRU bit, which is unused when WAYS = 1.
- Request: p1_MemRead_i | p1_MemWrite_i. The CPU holds the address and data stable while p1_stall_o is high.
- FSM states: IDLE, WRITEBACK, ALLOCATE, FILL.
- IDLE, no request: nothing changes.
- IDLE, hit (valid and tag match in any way):
  - p1_stall_o = 0.
  - Load: p1_data_o is the selected word, combinationally.
  - Store: at the clock edge, write the word into the line and set dirty.
  - LRU[set] is set to the way not accessed.
  - hit_cnt_o increments.
- IDLE, miss:
  - p1_stall_o = 1 and miss_cnt_o increments.
  - Victim: the lowest-numbered invalid way; otherwise way LRU[set]. The victim is latched.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line. On mem_ack_i, go to ALLOCATE.
- ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {request tag, index, 5'b0}. On mem_ack_i, capture mem_data_i and go to FILL.
- FILL:
  - Write the captured line into the victim way with valid = 1, dirty = 0 and the request tag.
  - Go to IDLE, where the request is re-evaluated and hits.
  - A flag suppresses the hit_cnt_o increment for this retried access, so each access counts exactly once.
- p1_stall_o = 1 whenever the state is not IDLE.
- Counters wrap modulo 2^CNT_W.
- mem_enable_o, mem_write_o and mem_addr_o are decoded from the state and latched victim or request fields. They stay stable until mem_ack_i.

## Timing
- Reset (asynchronous, rst_i = 0):
  - State = IDLE; all valid, dirty and LRU bits = 0; counters = 0.
  - mem_enable_o = 0 and mem_write_o = 0 immediately; mem_addr_o = 0, mem_data_o = 0.
  - p1_stall_o = 0 unless a request is present and misses.
  - Tag and data arrays are not reset.
- Reset mid-miss: the FSM aborts to IDLE and the in-flight write-back is discarded. Memory must tolerate mem_enable_o dropping without an ack.
- Hit latency: 0 stall cycles.
- Clean miss, with ack in the k-th ALLOCATE cycle:
  - p1_stall_o is high for k+2 cycles: 1 IDLE-miss cycle, k ALLOCATE cycles, 1 FILL cycle.
  - p1_stall_o is low in the next cycle, together with valid p1_data_o.
- Dirty miss: add j cycles, where j is the WRITEBACK ack latency.
- mem_ack_i is ignored outside WRITEBACK and ALLOCATE.
- A request that drops while the FSM is in WRITEBACK or ALLOCATE still completes the line operation. No hit is counted for it.

## Test plan
- Reset, then load 0x0000_0040 with memory ack after 3 cycles:
  - stall high for 5 cycles, one ALLOCATE at 0x40;
  - the load returns word 0 of the line;
  - miss_cnt_o = 1, hit_cnt_o = 0.
- Store 0xDEADBEEF to 0x44 after the previous test, then load 0x44:
  - no stall on either access;
  - the load returns 0xDEADBEEF;
  - hit_cnt_o increments by 2.
- SETS = 16, WAYS = 2; load 0x000, 0x200, 0x000 (same set), then 0x400:
  - the line at 0x200 (the LRU way) is evicted;
  - a following load of 0x000 hits.
- Store to 0x000, then evict it with 0x200 and 0x400:
  - WRITEBACK at 0x000 with mem_write_o = 1 and the stored word in the line, before the ALLOCATE at 0x400;
  - stall length = k + j + 2.
- Assert rst_i low during ALLOCATE:
  - mem_enable_o drops asynchronously;
  - counters = 0;
  - a reload of the same address misses.
- CNT_W = 4, 17 hits: hit_cnt_o = 1 (wrap).
